axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning log2 of memory depth in 64-bit words.
REQ-002 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port aw_valid  in  1  write address valid.
REQ-005 SHALL have port aw_ready  out  1  write address accept.
REQ-006 SHALL have port aw_addr  in  32  write byte address.
REQ-007 SHALL have port aw_id  in  4  write transaction ID.
REQ-008 SHALL have port aw_len  in  8  write beats minus one.
REQ-009 SHALL have port w_valid  in  1  write data valid.
REQ-010 SHALL have port w_ready  out  1  write data accept.
REQ-011 SHALL have port w_data  in  64  write data beat.
REQ-012 SHALL have port w_strb  in  8  byte enables; bit i covers w_data[8i+7:8i].
REQ-013 SHALL have port w_last  in  1  final write beat.
REQ-014 SHALL have port b_valid  out  1  write response valid.
REQ-015 SHALL have port b_ready  in  1  write response accept.
REQ-016 SHALL have port b_resp  out  2  00 OKAY, 10 SLVERR.
REQ-017 SHALL have port b_id  out  4  echoed aw_id.
REQ-018 SHALL have port ar_valid  in  1  read address valid.
REQ-019 SHALL have port ar_ready  out  1  read address accept.
REQ-020 SHALL have port ar_addr  in  32  read byte address.
REQ-021 SHALL have port ar_id  in  4  read transaction ID.
REQ-022 SHALL have port ar_len  in  8  read beats minus one.
REQ-023 SHALL have port r_valid  out  1  read data valid.
REQ-024 SHALL have port r_ready  in  1  read data accept.
REQ-025 SHALL have port r_data  out  64  read data beat.
REQ-026 SHALL have port r_resp  out  2  always 00.
REQ-027 SHALL have port r_last  out  1  final read beat.
REQ-028 SHALL have port r_id  out  4  echoed ar_id.

Function
REQ-029 SHALL hold 2^MEM_AW x 64-bit words; the word index SHALL be addr[MEM_AW+2:3]; the upper and low 3 address bits SHALL be ignored; the burst type SHALL be fixed INCR with 8-byte beats.
REQ-030 SHALL implement FSM states IDLE, RD, WR and WB, serving one transaction at a time.
REQ-031 In IDLE, ar_ready SHALL be 1 and aw_ready SHALL equal !ar_valid, giving reads priority when both are presented in the same cycle.
REQ-032 On an ar handshake, the block SHALL latch index, len and id, clear the beat count, and go to RD; r_valid SHALL rise the next cycle.
REQ-033 In RD: r_valid=1, r_data=mem[index], r_last=(beat==len). On r_valid&&r_ready, if r_last, go to IDLE; otherwise increment index (mod depth) and beat.
REQ-034 While r_valid=1 and r_ready=0, r_data, r_last and r_id SHALL be held stable.
REQ-035 On an aw handshake, the block SHALL latch index, len and id, clear the beat count and the error flag, and go to WR.
REQ-036 In WR: w_ready=1. Each w_valid beat SHALL write only the strobed bytes of mem[index], then increment index (mod depth) and beat.
REQ-037 In WR, w_last SHALL end the burst and move to WB; if w_last occurs on a beat other than len, or beat len arrives without w_last, the error flag SHALL be set.
REQ-038 In WB: b_valid=1, b_id=latched id, b_resp=10 if the error flag is set, else 00. b_valid&&b_ready SHALL return to IDLE; outputs SHALL be held until then.
REQ-039 aw_ready, w_ready and ar_ready SHALL be 0 outside IDLE/WR as applicable; no combinational path from any *_valid input to r_data.

Reset
REQ-040 While reset=0, the block SHALL go to IDLE; r_valid, b_valid, w_ready, r_last=0; r_data, r_id, b_id, b_resp, r_resp=0; ar_ready=1; aw_ready=!ar_valid; memory contents SHALL NOT be reset.
REQ-041 Reset asserted mid-burst SHALL abort the transaction with no B or R response issued; writes already committed SHALL remain.

Verification
REQ-042 Write aw_addr=0x10, len=0, w_data=0x1122334455667788, strb=FF, last=1 -> b_resp=00, b_id=aw_id; then read ar_addr=0x10 -> r_data=0x1122334455667788, r_last=1, first r_valid one cycle after ar handshake.
REQ-043 4-beat write at index 0xFE (addr 0x7F0) -> data lands at indexes FE, FF, 00, 01 (wrap); a 4-beat read at the same address returns the same data, with r_last on beat 4 only.
REQ-044 Write strb=0x0F data=0xFFFFFFFFFFFFFFFF over 0 -> read returns 0x00000000FFFFFFFF.
REQ-045 ar_valid and aw_valid asserted in the same cycle -> read served first (aw_ready=0 that cycle); the write completes after the read.
REQ-046 Write with len=3 but w_last on beat 2 -> b_resp=10; r_ready held low for 5 cycles during a read -> r_data stable; reset asserted mid-read -> r_valid=0 immediately, IDLE next.

Source files
------------

// File: rtl/axi_mem_slave_if.sv
`timescale 1ns/1ps
// axi_mem_slave_if
// Purpose : AXI-style bus bundle between a master and axi_mem_slave.
//           It carries five channels. AW and W carry the write address and
//           data, B carries the write response, AR carries the read address
//           and R carries the read data.
// Modports: master drives the valids and request fields and consumes the readies.
//           slave is the mirror image of master.
interface axi_mem_slave_if;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [3:0]  aw_id;
  logic [7:0]  aw_len;

  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;

  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
`timescale 1ns/1ps
// axi_mem_slave
// Purpose : single-outstanding AXI-style memory slave.
//           The memory holds 2^MEM_AW words of 64 bits each.
//           Bursts are INCR only, with 8-byte beats.
//           The word index wraps modulo the memory depth.
// Ports   : clock - rising-edge clock.
//           reset - asynchronous, active-low.
//           bus   - slave modport of axi_mem_slave_if, carrying the AW/W/B/AR/R channels.
//
// state | meaning
// IDLE  | ready for a new address; AR has priority over AW
// RD    | presenting read beats on R
// WR    | accepting write beats on W
// WB    | presenting the write response on B
module axi_mem_slave #(
  parameter int MEM_AW = 8
) (
  input logic            clock,
  input logic            reset,
  axi_mem_slave_if.slave bus
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

  state_t            state;
  logic [63:0]       mem [DEPTH];
  logic [MEM_AW-1:0] index;
  logic [MEM_AW-1:0] index_nxt;
  logic [MEM_AW-1:0] ar_index;
  logic [MEM_AW-1:0] aw_index;
  logic [7:0]        len;
  logic [7:0]        beat;
  logic              err;

  logic              r_valid_q;
  logic              r_last_q;
  logic [63:0]       r_data_q;
  logic [3:0]        r_id_q;
  logic              w_ready_q;
  logic              b_valid_q;
  logic [1:0]        b_resp_q;
  logic [3:0]        b_id_q;

  logic              unused_addr_bits;

  assign index_nxt = index + 1'b1;
  assign ar_index  = bus.ar_addr[MEM_AW+2:3];
  assign aw_index  = bus.aw_addr[MEM_AW+2:3];

  assign unused_addr_bits = ^{bus.ar_addr[31:MEM_AW+3], bus.ar_addr[2:0],
                              bus.aw_addr[31:MEM_AW+3], bus.aw_addr[2:0]};

  assign bus.ar_ready = (state == IDLE);
  assign bus.aw_ready = (state == IDLE) && !bus.ar_valid;
  assign bus.w_ready  = w_ready_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.b_id     = b_id_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_data   = r_data_q;
  assign bus.r_last   = r_last_q;
  assign bus.r_id     = r_id_q;
  assign bus.r_resp   = 2'b00;

  // Memory is not reset. Writes happen only while in WR, so a reset
  // (which forces IDLE asynchronously) stops further commits at once.
  always_ff @(posedge clock) begin
    if (state == WR && bus.w_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.w_strb[i]) mem[index][8*i +: 8] <= bus.w_data[8*i +: 8];
      end
    end
  end

  // r_data is loaded one beat ahead from the registered index. This keeps it
  // stable under back-pressure and keeps any *_valid input out of its path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= '0;
      len       <= '0;
      beat      <= '0;
      err       <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
      w_ready_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
      b_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ar_valid) begin
            index     <= ar_index;
            len       <= bus.ar_len;
            beat      <= '0;
            r_id_q    <= bus.ar_id;
            r_data_q  <= mem[ar_index];
            r_last_q  <= (bus.ar_len == 8'd0);
            r_valid_q <= 1'b1;
            state     <= RD;
          end else if (bus.aw_valid) begin
            index     <= aw_index;
            len       <= bus.aw_len;
            beat      <= '0;
            err       <= 1'b0;
            b_id_q    <= bus.aw_id;
            w_ready_q <= 1'b1;
            state     <= WR;
          end
        end
        RD: begin
          if (bus.r_ready) begin
            if (r_last_q) begin
              r_valid_q <= 1'b0;
              r_last_q  <= 1'b0;
              state     <= IDLE;
            end else begin
              index    <= index_nxt;
              beat     <= beat + 8'd1;
              r_data_q <= mem[index_nxt];
              r_last_q <= ((beat + 8'd1) == len);
            end
          end
        end
        WR: begin
          if (bus.w_valid) begin
            index <= index_nxt;
            beat  <= beat + 8'd1;
            if (bus.w_last) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= (err || beat != len) ? 2'b10 : 2'b00;
              state     <= WB;
            end else if (beat == len) begin
              err <= 1'b1;
            end
          end
        end
        WB: begin
          if (bus.b_ready) begin
            b_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
`timescale 1ns/1ps
module tb_axi_mem_slave;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [63:0] wdat [8];
  logic [63:0] rdat [8];
  logic        rlast [8];
  logic [3:0]  rid;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  axi_mem_slave_if bus ();

  axi_mem_slave #(.MEM_AW(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input int nbeats, input logic [7:0] strb,
                          output logic [1:0] resp, output logic [3:0] b_id);
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_id    = id;
    bus.aw_len   = len;
    #1;
    for (int k = 0; k < 20 && !bus.aw_ready; k++) step();
    check("aw_ready", bus.aw_ready, 1);
    step();
    bus.aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = wdat[i];
      bus.w_strb  = strb;
      bus.w_last  = (i == nbeats - 1);
      #1;
      for (int k = 0; k < 20 && !bus.w_ready; k++) step();
      check("w_ready", bus.w_ready, 1);
      step();
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
    for (int k = 0; k < 20 && !bus.b_valid; k++) step();
    check("b_valid", bus.b_valid, 1);
    resp = bus.b_resp;
    b_id = bus.b_id;
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
    bus.ar_id    = id;
    bus.ar_len   = len;
    #1;
    for (int k = 0; k < 20 && !bus.ar_ready; k++) step();
    check("ar_ready", bus.ar_ready, 1);
    step();
    bus.ar_valid = 1'b0;
    check("r_valid_after_ar", bus.r_valid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      bus.r_ready = 1'b1;
      for (int k = 0; k < 20 && !bus.r_valid; k++) step();
      rdat[i]  = bus.r_data;
      rlast[i] = bus.r_last;
      rid      = bus.r_id;
      step();
    end
    bus.r_ready = 1'b0;
  endtask

  initial begin
    bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_id = 0; bus.aw_len = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
    bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_id = 0; bus.ar_len = 0;
    bus.r_ready = 0;

    // Reset values
    #12;
    check("rst_r_valid", bus.r_valid, 0);
    check("rst_b_valid", bus.b_valid, 0);
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_r_last", bus.r_last, 0);
    check("rst_r_data", bus.r_data, 0);
    check("rst_r_id", bus.r_id, 0);
    check("rst_b_id", bus.b_id, 0);
    check("rst_b_resp", bus.b_resp, 0);
    check("rst_r_resp", bus.r_resp, 0);
    check("rst_ar_ready", bus.ar_ready, 1);
    check("rst_aw_ready", bus.aw_ready, 1);
    bus.ar_valid = 1'b1;
    #1;
    check("rst_aw_ready_arv", bus.aw_ready, 0);
    bus.ar_valid = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Single-beat write then read
    wdat[0] = 64'h1122334455667788;
    do_write(32'h10, 4'h5, 8'd0, 1, 8'hFF, bresp, bid);
    check("t1_b_resp", bresp, 2'b00);
    check("t1_b_id", bid, 4'h5);
    do_read(32'h10, 4'h3, 8'd0);
    check("t1_r_data", rdat[0], 64'h1122334455667788);
    check("t1_r_last", rlast[0], 1);
    check("t1_r_id", rid, 4'h3);

    // 4-beat write wrapping from index FE
    wdat[0] = 64'hA0A0_0000_0000_00FE;
    wdat[1] = 64'hA1A1_0000_0000_00FF;
    wdat[2] = 64'hA2A2_0000_0000_0000;
    wdat[3] = 64'hA3A3_0000_0000_0001;
    do_write(32'h7F0, 4'hA, 8'd3, 4, 8'hFF, bresp, bid);
    check("t2_b_resp", bresp, 2'b00);
    check("t2_b_id", bid, 4'hA);
    do_read(32'h7F0, 4'hB, 8'd3);
    check("t2_d0", rdat[0], 64'hA0A0_0000_0000_00FE);
    check("t2_d1", rdat[1], 64'hA1A1_0000_0000_00FF);
    check("t2_d2", rdat[2], 64'hA2A2_0000_0000_0000);
    check("t2_d3", rdat[3], 64'hA3A3_0000_0000_0001);
    check("t2_last0", rlast[0], 0);
    check("t2_last1", rlast[1], 0);
    check("t2_last2", rlast[2], 0);
    check("t2_last3", rlast[3], 1);
    do_read(32'h0, 4'h1, 8'd0);
    check("t2_idx00", rdat[0], 64'hA2A2_0000_0000_0000);
    do_read(32'h8, 4'h1, 8'd0);
    check("t2_idx01", rdat[0], 64'hA3A3_0000_0000_0001);

    // Partial strobe over zero
    wdat[0] = 64'h0;
    do_write(32'h20, 4'h2, 8'd0, 1, 8'hFF, bresp, bid);
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h20, 4'h2, 8'd0, 1, 8'h0F, bresp, bid);
    do_read(32'h20, 4'h2, 8'd0);
    check("t3_strb", rdat[0], 64'h0000_0000_FFFF_FFFF);

    // Simultaneous AR and AW: read first
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h10;  bus.ar_id = 4'h6; bus.ar_len = 8'd0;
    bus.aw_valid = 1'b1; bus.aw_addr = 32'h18;  bus.aw_id = 4'h7; bus.aw_len = 8'd0;
    #1;
    check("t4_aw_ready_blocked", bus.aw_ready, 0);
    check("t4_ar_ready", bus.ar_ready, 1);
    step();
    bus.ar_valid = 1'b0;
    #1;
    check("t4_r_valid", bus.r_valid, 1);
    check("t4_r_data", bus.r_data, 64'h1122334455667788);
    check("t4_aw_ready_rd", bus.aw_ready, 0);
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    #1;
    check("t4_aw_ready_after", bus.aw_ready, 1);
    step();
    bus.aw_valid = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = 64'hCAFE_F00D_DEAD_BEEF; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
    #1;
    check("t4_w_ready", bus.w_ready, 1);
    step();
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    check("t4_b_valid", bus.b_valid, 1);
    check("t4_b_id", bus.b_id, 4'h7);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    do_read(32'h18, 4'h0, 8'd0);
    check("t4_w_data", rdat[0], 64'hCAFE_F00D_DEAD_BEEF);

    // Early w_last (len=3, last on third beat) and missing w_last
    wdat[0] = 64'h1; wdat[1] = 64'h2; wdat[2] = 64'h3;
    do_write(32'h100, 4'hC, 8'd3, 3, 8'hFF, bresp, bid);
    check("t5_early_last", bresp, 2'b10);
    check("t5_b_id", bid, 4'hC);
    do_write(32'h100, 4'hD, 8'd1, 3, 8'hFF, bresp, bid);
    check("t5_late_last", bresp, 2'b10);
    do_write(32'h100, 4'hE, 8'd2, 3, 8'hFF, bresp, bid);
    check("t5_exact_last", bresp, 2'b00);

    // Back-pressure on R
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h7F0; bus.ar_id = 4'h9; bus.ar_len = 8'd1;
    step();
    bus.ar_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("t6_stall_valid", bus.r_valid, 1);
      check("t6_stall_data", bus.r_data, 64'hA0A0_0000_0000_00FE);
      check("t6_stall_last", bus.r_last, 0);
      check("t6_stall_id", bus.r_id, 4'h9);
      step();
    end
    bus.r_ready = 1'b1;
    step();
    check("t6_beat1_data", bus.r_data, 64'hA1A1_0000_0000_00FF);
    check("t6_beat1_last", bus.r_last, 1);
    step();
    bus.r_ready = 1'b0;
    check("t6_done", bus.r_valid, 0);

    // Reset mid-read
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h7F0; bus.ar_id = 4'h2; bus.ar_len = 8'd3;
    step();
    bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    check("t7_mid_read", bus.r_valid, 1);
    reset = 1'b0;
    #1;
    check("t7_rst_r_valid", bus.r_valid, 0);
    check("t7_rst_ar_ready", bus.ar_ready, 1);
    check("t7_rst_r_data", bus.r_data, 0);
    step();
    reset = 1'b1;
    step();
    check("t7_idle_r_valid", bus.r_valid, 0);
    check("t7_idle_b_valid", bus.b_valid, 0);
    do_read(32'h7F0, 4'h4, 8'd0);
    check("t7_mem_kept", rdat[0], 64'hA0A0_0000_0000_00FE);

    // Reset mid-write: committed beat stays, no B response
    bus.aw_valid = 1'b1; bus.aw_addr = 32'h40; bus.aw_id = 4'h1; bus.aw_len = 8'd3;
    step();
    bus.aw_valid = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = 64'h5555_AAAA_1234_5678; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
    step();
    bus.w_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("t8_rst_w_ready", bus.w_ready, 0);
    check("t8_rst_b_valid", bus.b_valid, 0);
    step();
    reset = 1'b1;
    step();
    check("t8_no_b", bus.b_valid, 0);
    do_read(32'h40, 4'h8, 8'd0);
    check("t8_committed", rdat[0], 64'h5555_AAAA_1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
